// File: rtl/spo2_msg_tx_if.sv
// Handshake bundle between the SpO2 line formatter, its requester and the UART TX byte engine.
interface spo2_msg_tx_if;
  logic       send_req;
  logic [7:0] spo2_value;
  logic       spo2_valid;
  logic       tx_done;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       busy;
  logic       done;

  modport master (
    output send_req, spo2_value, spo2_valid, tx_done,
    input  tx_byte, tx_start, busy, done
  );

  modport slave (
    input  send_req, spo2_value, spo2_valid, tx_done,
    output tx_byte, tx_start, busy, done
  );
endinterface

// File: rtl/spo2_msg_tx.sv
// Streams "+SPO2=<value>\r\n" (or "+SPO2=N\r\n" when invalid) one byte per UART handshake.
module spo2_msg_tx (
  input  logic         clk,
  input  logic         rst,
  spo2_msg_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] cap_value;
  logic       cap_valid;
  logic [3:0] idx;
  logic [1:0] n_chars;
  logic [7:0] chars [0:2];
  logic       done_q;
  logic [7:0] byte_q;

  logic [1:0] hund;
  logic [3:0] tens;
  logic [7:0] rem_h, rem_t;
  logic [3:0] idx_nxt, ci;
  logic [7:0] byte_nxt;
  logic       last;

  // Constant compare/subtract BCD split; rem_t ends up holding the units digit.
  always_comb begin
    hund  = 2'd0;
    rem_h = cap_value;
    if (cap_value >= 8'd200) begin
      hund  = 2'd2;
      rem_h = cap_value - 8'd200;
    end else if (cap_value >= 8'd100) begin
      hund  = 2'd1;
      rem_h = cap_value - 8'd100;
    end
    tens  = 4'd0;
    rem_t = rem_h;
    for (int unsigned i = 1; i < 10; i++) begin
      if (rem_h >= 8'(10 * i)) begin
        tens  = 4'(i);
        rem_t = rem_h - 8'(10 * i);
      end
    end
  end

  assign last = (idx == 4'd7 + {2'b00, n_chars});

  // Byte that follows the current one; byte 0 is loaded directly from LOAD.
  always_comb begin
    idx_nxt  = idx + 4'd1;
    ci       = idx_nxt - 4'd6;
    byte_nxt = 8'h0A;
    case (idx_nxt)
      4'd1:    byte_nxt = 8'h53;
      4'd2:    byte_nxt = 8'h50;
      4'd3:    byte_nxt = 8'h4F;
      4'd4:    byte_nxt = 8'h32;
      4'd5:    byte_nxt = 8'h3D;
      default: begin
        if (ci < {2'b00, n_chars})
          byte_nxt = chars[ci[1:0]];
        else if (ci == {2'b00, n_chars})
          byte_nxt = 8'h0D;
        else
          byte_nxt = 8'h0A;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.send_req) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    state_nxt = WAIT;
      WAIT:    if (bus.tx_done) state_nxt = last ? IDLE : SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_value <= '0;
      cap_valid <= 1'b0;
      idx       <= '0;
      n_chars   <= 2'd1;
      chars     <= '{default: '0};
      byte_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == WAIT) && bus.tx_done && last;
      case (state)
        IDLE: begin
          if (bus.send_req) begin
            cap_value <= bus.spo2_value;
            cap_valid <= bus.spo2_valid;
          end
        end
        LOAD: begin
          idx    <= '0;
          byte_q <= 8'h2B;
          chars  <= '{default: '0};
          if (!cap_valid) begin
            n_chars  <= 2'd1;
            chars[0] <= 8'h4E;
          end else if (hund != 2'd0) begin
            n_chars  <= 2'd3;
            chars[0] <= 8'h30 + {6'b0, hund};
            chars[1] <= 8'h30 + {4'b0, tens};
            chars[2] <= 8'h30 + rem_t;
          end else if (tens != 4'd0) begin
            n_chars  <= 2'd2;
            chars[0] <= 8'h30 + {4'b0, tens};
            chars[1] <= 8'h30 + rem_t;
          end else begin
            n_chars  <= 2'd1;
            chars[0] <= 8'h30 + rem_t;
          end
        end
        WAIT: begin
          if (bus.tx_done && !last) begin
            idx    <= idx_nxt;
            byte_q <= byte_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_start = (state == SEND);
  assign bus.busy     = (state != IDLE);
  assign bus.tx_byte  = byte_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_spo2_msg_tx.sv
// Directed bench for spo2_msg_tx: expected lines built from formatted strings, checked every cycle.
module tb_spo2_msg_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spo2_msg_tx_if bus();
  spo2_msg_tx dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int done_cnt = 0;
  bit inj_start = 1'b0;
  bit inj_idle  = 1'b0;
  byte unsigned exp_q[$];
  byte unsigned got_q[$];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_line(input int v, input bit valid);
    string s;
    if (valid) s = $sformatf("+SPO2=%0d\r\n", v);
    else       s = "+SPO2=N\r\n";
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endfunction

  // UART stand-in: tx_done 10 cycles after each tx_start, plus optional spurious pulses.
  int cd = 0;
  initial begin : uart
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.tx_done = 1'b1;
      end
      if (bus.tx_start) begin
        cd = 10;
        if (inj_start) bus.tx_done = 1'b1;
      end
      if (inj_idle) bus.tx_done = 1'b1;
    end
  end

  // Compare process: byte order, byte hold while outstanding, done one cycle after last byte.
  bit           pending  = 1'b0;
  bit           exp_done = 1'b0;
  byte unsigned last_b   = 8'h00;
  byte unsigned b;
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pending  = 1'b0;
        exp_done = 1'b0;
      end else begin
        chk(bus.done == exp_done, "done", bus.done, exp_done);
        if (bus.done) done_cnt++;
        exp_done = 1'b0;
        if (bus.tx_start) begin
          starts++;
          got_q.push_back(bus.tx_byte);
          chk(exp_q.size() != 0, "extra_byte", bus.tx_byte, 0);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk(bus.tx_byte == b, "byte", bus.tx_byte, b);
          end
          last_b  = bus.tx_byte;
          pending = 1'b1;
        end else if (pending) begin
          chk(bus.tx_byte == last_b, "hold", bus.tx_byte, last_b);
          if (bus.tx_done) begin
            pending  = 1'b0;
            exp_done = (last_b == 8'h0A);
          end
        end
      end
    end
  end

  task automatic start_line(input logic [7:0] v, input logic valid);
    push_line(v, valid);
    got_q.delete();
    bus.spo2_value = v;
    bus.spo2_valid = valid;
    bus.send_req   = 1'b1;
    tick();
    bus.send_req   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "done_timeout", seen, 1);
  endtask

  task automatic wait_starts(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (starts >= target) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(seen, "start_timeout", starts, target);
  endtask

  task automatic send_line(input logic [7:0] v, input logic valid);
    start_line(v, valid);
    wait_done(400);
  endtask

  byte unsigned exp98 [10] = '{8'h2B, 8'h53, 8'h50, 8'h4F, 8'h32, 8'h3D, 8'h39, 8'h38, 8'h0D, 8'h0A};
  byte unsigned vals  [4]  = '{8'd0, 8'd5, 8'd100, 8'd255};
  int           lens  [4]  = '{9, 9, 11, 11};
  int s0, d0;

  initial begin : main
    rst = 1'b1;
    bus.send_req   = 1'b0;
    bus.spo2_value = 8'd0;
    bus.spo2_valid = 1'b0;
    repeat (3) tick();
    chk(bus.tx_byte == 8'h00, "rst_tx_byte", bus.tx_byte, 0);
    chk(bus.tx_start == 1'b0, "rst_tx_start", bus.tx_start, 0);
    chk(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
    chk(bus.done == 1'b0, "rst_done", bus.done, 0);
    rst = 1'b0;
    tick();

    // Value 98: latency, full stream, pulse count, single done.
    s0 = starts;
    d0 = done_cnt;
    start_line(8'd98, 1'b1);
    chk(bus.busy == 1'b1, "busy_T1", bus.busy, 1);
    chk(bus.tx_start == 1'b0, "load_quiet", bus.tx_start, 0);
    tick();
    chk(bus.tx_start == 1'b1, "start_T2", bus.tx_start, 1);
    chk(bus.tx_byte == 8'h2B, "first_byte", bus.tx_byte, 8'h2B);
    wait_done(400);
    chk(bus.busy == 1'b0, "busy_end", bus.busy, 0);
    chk(bus.tx_byte == 8'h0A, "hold_last", bus.tx_byte, 8'h0A);
    tick();
    chk(starts - s0 == 10, "start_count", starts - s0, 10);
    chk(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
    chk(got_q.size() == 10, "len98", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk(got_q[i] == exp98[i], "lit98", got_q[i], exp98[i]);

    // Boundary values, launched back-to-back in the done cycle.
    for (int k = 0; k < 4; k++) begin
      send_line(vals[k], 1'b1);
      chk(got_q.size() == lens[k], "line_len", got_q.size(), lens[k]);
    end
    if (got_q.size() == 11) begin
      chk(got_q[6] == 8'h32, "lit255_h", got_q[6], 8'h32);
      chk(got_q[8] == 8'h35, "lit255_u", got_q[8], 8'h35);
    end
    tick();

    // Invalid measurement.
    send_line(8'd97, 1'b0);
    chk(got_q.size() == 9, "len_inv", got_q.size(), 9);
    if (got_q.size() > 6) chk(got_q[6] == 8'h4E, "lit_N", got_q[6], 8'h4E);
    tick();

    // send_req with a new value during the third byte's WAIT.
    s0 = starts;
    d0 = done_cnt;
    start_line(8'd98, 1'b1);
    wait_starts(s0 + 3);
    repeat (2) tick();
    bus.spo2_value = 8'd50;
    bus.send_req   = 1'b1;
    tick();
    bus.send_req   = 1'b0;
    wait_done(400);
    repeat (40) tick();
    chk(starts - s0 == 10, "no_queue_starts", starts - s0, 10);
    chk(done_cnt - d0 == 1, "no_queue_done", done_cnt - d0, 1);

    // Reset during the first digit byte.
    s0 = starts;
    start_line(8'd98, 1'b1);
    wait_starts(s0 + 7);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk(bus.tx_byte == 8'h00, "abort_tx_byte", bus.tx_byte, 0);
    chk(bus.tx_start == 1'b0, "abort_tx_start", bus.tx_start, 0);
    chk(bus.busy == 1'b0, "abort_busy", bus.busy, 0);
    chk(bus.done == 1'b0, "abort_done", bus.done, 0);
    rst = 1'b0;
    d0 = done_cnt;
    s0 = starts;
    repeat (30) tick();
    chk(done_cnt == d0, "abort_no_done", done_cnt, d0);
    chk(starts == s0, "abort_no_bytes", starts, s0);
    send_line(8'd7, 1'b1);
    chk(got_q.size() == 9, "len7", got_q.size(), 9);
    if (got_q.size() > 6) chk(got_q[6] == 8'h37, "lit7", got_q[6], 8'h37);
    tick();

    // Spurious tx_done in IDLE and in every SEND cycle.
    inj_idle = 1'b1;
    tick();
    inj_idle = 1'b0;
    tick();
    chk(bus.busy == 1'b0, "idle_done_busy", bus.busy, 0);
    chk(bus.tx_start == 1'b0, "idle_done_start", bus.tx_start, 0);
    inj_start = 1'b1;
    send_line(8'd42, 1'b1);
    inj_start = 1'b0;
    chk(got_q.size() == 10, "len42", got_q.size(), 10);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
